program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot-time sequencer that fills the 16x8 RAM through the MAR/RAM manual-programming path.
//  On start it fetches each word from a source (UART buffer/flash/ROM) over a req/valid
//  handshake, strobes the MAR manual load then the RAM manual write, for every address
//  0..2^ADDR_W-1 in order. Holds the CPU (cpu_hold, ORed into CPU reset in top) until done.
// PARAMETERS
//  ADDR_W   4     RAM address width; word count = 2**ADDR_W
//  DATA_W   8     RAM word width
//  TIMEOUT  1024  max cycles in FETCH waiting for src_valid before error; >=2
// PORTS
//  clk              in   1       system clock; the one and only clock
//  rst              in   1       reset, synchronous, active-low
//  start            in   1       begin load; sampled only in IDLE, DONE, ERROR
//  abort            in   1       cancel load; returns to IDLE
//  src_req          out  1       word request to source
//  src_addr         out  ADDR_W  address of requested word; stable while src_req=1
//  src_valid        in   1       src_data valid; accepted only when src_req=1
//  src_data         in   DATA_W  program word
//  manual_mode      out  1       selects manual path on MAR and RAM
//  mar_manual_read  out  1       1-cycle strobe: MAR loads mar_switches
//  mar_switches     out  ADDR_W  address to MAR
//  ram_manual_read  out  1       1-cycle strobe: RAM writes ram_switches at MAR address
//  ram_switches     out  DATA_W  data to RAM
//  cpu_hold         out  1       keeps CPU in reset while loading
//  busy             out  1       1 in FETCH/LOAD_MAR/WRITE_RAM
//  done             out  1       level; 1 in DONE state
//  error            out  1       level; 1 in ERROR state (source timeout)
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE; every output 0; addr=0; timeout counter=0.
//  States: IDLE, FETCH, LOAD_MAR, WRITE_RAM, DONE, ERROR.
//   IDLE: start=1 -> FETCH, addr=0, cpu_hold=1, manual_mode=1.
//   FETCH: src_req=1, src_addr=addr. src_valid=1 -> latch src_data into word reg,
//     -> LOAD_MAR. Min 1 cycle (valid in same cycle as req). Counter increments each
//     FETCH cycle without valid; at TIMEOUT-1 -> ERROR. Counter clears on leaving FETCH.
//   LOAD_MAR (1 cycle): mar_switches=addr, mar_manual_read=1.
//   WRITE_RAM (1 cycle): ram_switches=word reg, mar_switches held, ram_manual_read=1.
//     addr==2**ADDR_W-1 -> DONE; else addr+1 -> FETCH. addr never wraps to 0.
//   DONE: done=1, cpu_hold=0, manual_mode=0. start=1 -> FETCH (reload from 0).
//   ERROR: error=1, cpu_hold=1, manual_mode=0. start=1 -> FETCH (reload from 0).
//  Per word latency: (fetch cycles)+2; best-case full load 3*2**ADDR_W cycles.
//  mar/ram strobes never in same cycle; both 0 outside their states.
//  abort=1 in any state -> IDLE next edge, all outputs 0 (partial RAM contents kept).
//  abort wins over start and over src_valid in the same cycle. rst wins over all.
//  start while busy: ignored. src_valid outside FETCH: ignored, no data latched.
//  mar_switches/ram_switches are 0 whenever manual_mode=0.
//  All outputs registered (Moore); no combinational input->output path.
// STRUCTURE
//  cpu_pkg: ADDR_W/DATA_W defaults, loader_state_t enum (6 states).
//  Single module; timeout counter inline, no sub-module.
//  top: manual_mode/strobes/switches to u_mar and u_ram manual ports; CPU reset = ~rst | cpu_hold.
// TESTING
//  1 Zero-latency source (valid with req), data=addr^8'hA5 -> 16 writes, RAM[i]=i^A5,
//    done=1 at cycle 48 after start, cpu_hold falls same cycle.
//  2 Source 3-cycle latency -> 5 cycles/word, strobe order MAR then RAM, never overlap.
//  3 TIMEOUT=8, source silent at addr 5 -> error=1 8 cycles into FETCH, cpu_hold=1,
//    RAM[0..4] written; start -> reload from 0 completes done=1.
//  4 abort in WRITE_RAM of addr 9 -> next cycle IDLE, all outputs 0; start+abort same
//    cycle in IDLE -> stays IDLE.
//  5 rst=0 mid-FETCH with src_valid=1 -> all outputs 0 next edge, no write; start ignored
//    while busy (addr sequence unchanged).
//  6 Spurious src_valid in LOAD_MAR/DONE -> no latch, RAM contents unchanged.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader: state encoding, control-output
// bundle and the per-state control decode.
package program_loader_pkg;

    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD_MAR,
        ST_WRITE_RAM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef struct packed {
        logic src_req;
        logic manual_mode;
        logic mar_strobe;
        logic ram_strobe;
        logic cpu_hold;
        logic busy;
        logic done;
        logic error;
    } ctrl_t;

    // Single-bit control outputs are a pure function of the state being entered,
    // so they are registered together with the state itself.
    function automatic ctrl_t ctrl_for(input loader_state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.src_req     = 1'b1;
                c.manual_mode = 1'b1;
                c.cpu_hold    = 1'b1;
                c.busy        = 1'b1;
            end
            ST_LOAD_MAR: begin
                c.manual_mode = 1'b1;
                c.mar_strobe  = 1'b1;
                c.cpu_hold    = 1'b1;
                c.busy        = 1'b1;
            end
            ST_WRITE_RAM: begin
                c.manual_mode = 1'b1;
                c.ram_strobe  = 1'b1;
                c.cpu_hold    = 1'b1;
                c.busy        = 1'b1;
            end
            ST_DONE: begin
                c.done = 1'b1;
            end
            ST_ERROR: begin
                c.error    = 1'b1;
                c.cpu_hold = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Boot-time sequencer that copies 2**ADDR_W words from a req/valid source into the
// RAM through the MAR/RAM manual-programming path, holding the CPU until complete.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              src_req,
    output logic [ADDR_W-1:0] src_addr,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              manual_mode,
    output logic              mar_manual_read,
    output logic [ADDR_W-1:0] mar_switches,
    output logic              ram_manual_read,
    output logic [DATA_W-1:0] ram_switches,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output loader_state_t     state
);

    localparam int                CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    loader_state_t     state_q, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] word_q, word_next;
    logic [CNT_W-1:0]  count_q, count_next;
    ctrl_t             ctrl_q;
    logic [ADDR_W-1:0] src_addr_q;
    logic [ADDR_W-1:0] mar_sw_q;
    logic [DATA_W-1:0] ram_sw_q;

    // Next-state decode; abort overrides every state-local decision.
    always_comb begin
        state_next = state_q;
        addr_next  = addr_q;
        word_next  = word_q;
        count_next = '0;
        if (abort) begin
            state_next = ST_IDLE;
            addr_next  = '0;
            word_next  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_next = ST_FETCH;
                        addr_next  = '0;
                    end
                end
                ST_FETCH: begin
                    if (src_valid) begin
                        word_next  = src_data;
                        state_next = ST_LOAD_MAR;
                    end else if (count_q == CNT_LAST) begin
                        state_next = ST_ERROR;
                    end else begin
                        count_next = count_q + CNT_W'(1);
                    end
                end
                ST_LOAD_MAR: begin
                    state_next = ST_WRITE_RAM;
                end
                ST_WRITE_RAM: begin
                    if (addr_q == ADDR_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        addr_next  = addr_q + ADDR_W'(1);
                        state_next = ST_FETCH;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so they line up with it (Moore, registered).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            count_q    <= '0;
            ctrl_q     <= '0;
            src_addr_q <= '0;
            mar_sw_q   <= '0;
            ram_sw_q   <= '0;
        end else begin
            state_q    <= state_next;
            addr_q     <= addr_next;
            word_q     <= word_next;
            count_q    <= count_next;
            ctrl_q     <= ctrl_for(state_next);
            src_addr_q <= (state_next == ST_FETCH) ? addr_next : '0;
            mar_sw_q   <= (state_next == ST_LOAD_MAR || state_next == ST_WRITE_RAM)
                          ? addr_next : '0;
            ram_sw_q   <= (state_next == ST_WRITE_RAM) ? word_next : '0;
        end
    end

    assign state           = state_q;
    assign src_req         = ctrl_q.src_req;
    assign src_addr        = src_addr_q;
    assign manual_mode     = ctrl_q.manual_mode;
    assign mar_manual_read = ctrl_q.mar_strobe;
    assign mar_switches    = mar_sw_q;
    assign ram_manual_read = ctrl_q.ram_strobe;
    assign ram_switches    = ram_sw_q;
    assign cpu_hold        = ctrl_q.cpu_hold;
    assign busy            = ctrl_q.busy;
    assign done            = ctrl_q.done;
    assign error           = ctrl_q.error;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: behavioural source and MAR/RAM model, scenario tasks,
// expected-queue scoreboard and one summary line.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          src_req;
    logic [AW-1:0] src_addr;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          manual_mode;
    logic          mar_manual_read;
    logic [AW-1:0] mar_switches;
    logic          ram_manual_read;
    logic [DW-1:0] ram_switches;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    loader_state_t state;

    int checks = 0;
    int failures = 0;

    program_loader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_req(src_req), .src_addr(src_addr), .src_valid(src_valid), .src_data(src_data),
        .manual_mode(manual_mode), .mar_manual_read(mar_manual_read),
        .mar_switches(mar_switches), .ram_manual_read(ram_manual_read),
        .ram_switches(ram_switches), .cpu_hold(cpu_hold), .busy(busy),
        .done(done), .error(error), .state(state)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- source model ----------------
    logic [DW-1:0] seed = '0;
    int            src_lat = 1;
    logic          silent_en = 1'b0;
    logic [AW-1:0] silent_addr = '0;
    logic          spur_en = 1'b0;
    int            req_cycles = 0;

    function automatic logic [DW-1:0] src_word(input logic [DW-1:0] s, input int a);
        logic [DW-1:0] av;
        av = DW'(a);
        return s ^ av;
    endfunction

    // Responds shortly after each edge: valid on the src_lat-th cycle of a request.
    always begin
        @(posedge clk);
        #2;
        if (src_req) begin
            req_cycles++;
            if (!(silent_en && src_addr == silent_addr) && req_cycles >= src_lat) begin
                src_valid = 1'b1;
                src_data  = src_word(seed, int'(src_addr));
            end else begin
                src_valid = 1'b0;
                src_data  = DW'($urandom);
            end
        end else begin
            req_cycles = 0;
            src_valid  = spur_en;
            src_data   = DW'($urandom);
        end
    end

    // ---------------- MAR/RAM model and protocol monitor ----------------
    logic [AW-1:0] mar_q = '0;
    logic          mar_prev = 1'b0;
    logic          req_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    int            viol = 0;
    string         viol_msg = "none";
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];

    always @(negedge clk) begin
        if (mar_manual_read && ram_manual_read) begin
            viol++; viol_msg = "mar and ram strobes overlap";
        end
        if (ram_manual_read && !mar_prev) begin
            viol++; viol_msg = "ram strobe not preceded by mar strobe";
        end
        if (!manual_mode && (mar_switches != '0 || ram_switches != '0 ||
                             mar_manual_read || ram_manual_read)) begin
            viol++; viol_msg = "manual path active with manual_mode=0";
        end
        if (src_req && req_prev && src_addr != addr_prev) begin
            viol++; viol_msg = "src_addr moved during request";
        end
        if (ram_manual_read && mar_switches != mar_q) begin
            viol++; viol_msg = "mar_switches not held during ram write";
        end
        if (mar_manual_read) mar_q = mar_switches;
        if (ram_manual_read) begin
            wr_addr_q.push_back(mar_q);
            wr_data_q.push_back(ram_switches);
            wr_cyc_q.push_back(cyc);
        end
        mar_prev  = mar_manual_read;
        req_prev  = src_req;
        addr_prev = src_addr;
    end

    logic [DW-1:0] exp_q[$];

    // ---------------- drivers ----------------
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done || error) && n < limit);
        #1;
    endtask

    function automatic logic [39:0] all_outs();
        return 40'({src_req, src_addr, manual_mode, mar_manual_read, mar_switches,
                    ram_manual_read, ram_switches, cpu_hold, busy, done, error});
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", all_outs());
        end
        checks++;
        if (state !== ST_IDLE) begin
            failures++; $display("FAIL reset_state got=%0d want=%0d", state, ST_IDLE);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_latency();
        int n, base, v0, cnt;
        logic hold_prev;
        seed = 8'hA5; src_lat = 1;
        base = wr_data_q.size(); v0 = viol;
        pulse_start();
        n = 0; hold_prev = 1'b0;
        do begin
            hold_prev = cpu_hold;
            @(negedge clk);
            n++;
        end while (!(done || error) && n < 400);
        #1;
        checks++;
        if (n !== 3 * NWORDS || done !== 1'b1) begin
            failures++; $display("FAIL zero_lat_done_cycle got=%0d done=%b want=%0d", n, done, 3 * NWORDS);
        end
        checks++;
        if ({hold_prev, cpu_hold} !== 2'b10) begin
            failures++; $display("FAIL zero_lat_hold_release got=%b want=10", {hold_prev, cpu_hold});
        end
        checks++;
        if ({busy, manual_mode, error, src_req} !== 4'b0) begin
            failures++; $display("FAIL zero_lat_done_outputs got=%b want=0000", {busy, manual_mode, error, src_req});
        end
        exp_q.delete();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back(src_word(seed, i));
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== NWORDS) begin
            failures++; $display("FAIL zero_lat_write_count got=%0d want=%0d", cnt, NWORDS);
        end
        for (int i = 0; i < NWORDS && i < cnt; i++) begin
            checks++;
            if (wr_addr_q[base + i] !== AW'(i) || wr_data_q[base + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL zero_lat_ram[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, wr_addr_q[base + i], wr_data_q[base + i], i, exp_q[i]);
            end
        end
        checks++;
        if (viol !== v0) begin
            failures++; $display("FAIL zero_lat_protocol got=%0d violations (%s) want=0", viol - v0, viol_msg);
        end
    endtask

    task automatic test_latency();
        int n, base, v0, cnt, gap;
        seed = DW'($urandom); src_lat = 3;
        base = wr_data_q.size(); v0 = viol;
        pulse_start();
        wait_end(600, n);
        checks++;
        if (n !== 5 * NWORDS || done !== 1'b1) begin
            failures++; $display("FAIL lat3_done_cycle got=%0d done=%b want=%0d", n, done, 5 * NWORDS);
        end
        exp_q.delete();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back(src_word(seed, i));
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== NWORDS) begin
            failures++; $display("FAIL lat3_write_count got=%0d want=%0d", cnt, NWORDS);
        end
        for (int i = 0; i < NWORDS && i < cnt; i++) begin
            checks++;
            if (wr_addr_q[base + i] !== AW'(i) || wr_data_q[base + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL lat3_ram[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, wr_addr_q[base + i], wr_data_q[base + i], i, exp_q[i]);
            end
            if (i > 0) begin
                gap = wr_cyc_q[base + i] - wr_cyc_q[base + i - 1];
                checks++;
                if (gap !== 5) begin
                    failures++; $display("FAIL lat3_word_period[%0d] got=%0d want=5", i, gap);
                end
            end
        end
        checks++;
        if (viol !== v0) begin
            failures++; $display("FAIL lat3_protocol got=%0d violations (%s) want=0", viol - v0, viol_msg);
        end
        src_lat = 1;
    endtask

    task automatic test_timeout();
        int n, base, v0, cnt;
        seed = DW'($urandom); src_lat = 1;
        silent_en = 1'b1; silent_addr = AW'(5);
        base = wr_data_q.size(); v0 = viol;
        pulse_start();
        wait_end(400, n);
        // words 0..4 take 15 edges, then TIMEOUT cycles stuck in FETCH
        checks++;
        if (n !== 15 + TO || error !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL timeout_error_cycle got=%0d error=%b done=%b want=%0d error=1", n, error, done, 15 + TO);
        end
        checks++;
        if ({cpu_hold, busy, manual_mode, src_req} !== 4'b1000) begin
            failures++; $display("FAIL timeout_outputs got=%b want=1000", {cpu_hold, busy, manual_mode, src_req});
        end
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(src_word(seed, i));
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== 5) begin
            failures++; $display("FAIL timeout_write_count got=%0d want=5", cnt);
        end
        for (int i = 0; i < 5 && i < cnt; i++) begin
            checks++;
            if (wr_addr_q[base + i] !== AW'(i) || wr_data_q[base + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL timeout_ram[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, wr_addr_q[base + i], wr_data_q[base + i], i, exp_q[i]);
            end
        end
        silent_en = 1'b0;
        base = wr_data_q.size();
        pulse_start();
        wait_end(400, n);
        checks++;
        if (n !== 3 * NWORDS || done !== 1'b1 || error !== 1'b0) begin
            failures++; $display("FAIL timeout_reload got=%0d done=%b error=%b want=%0d done=1", n, done, error, 3 * NWORDS);
        end
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== NWORDS || (cnt > 0 && wr_addr_q[base] !== '0)) begin
            failures++; $display("FAIL timeout_reload_writes got=%0d want=%0d from addr 0", cnt, NWORDS);
        end
        checks++;
        if (viol !== v0) begin
            failures++; $display("FAIL timeout_protocol got=%0d violations (%s) want=0", viol - v0, viol_msg);
        end
    endtask

    task automatic test_abort();
        int n, base, v0, cnt;
        seed = DW'($urandom); src_lat = 1;
        base = wr_data_q.size(); v0 = viol;
        pulse_start();
        n = 0;
        while (!(ram_manual_read && mar_switches == AW'(9)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++; $display("FAIL abort_reach_addr9 got=timeout want=write of addr 9");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (all_outs() !== '0 || state !== ST_IDLE) begin
            failures++; $display("FAIL abort_outputs got=%h state=%0d want=0 state=%0d", all_outs(), state, ST_IDLE);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (all_outs() !== '0 || state !== ST_IDLE) begin
            failures++; $display("FAIL abort_beats_start got=%h state=%0d want=0 state=%0d", all_outs(), state, ST_IDLE);
        end
        repeat (4) @(negedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(src_word(seed, i));
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== 10) begin
            failures++; $display("FAIL abort_write_count got=%0d want=10", cnt);
        end
        for (int i = 0; i < 10 && i < cnt; i++) begin
            checks++;
            if (wr_addr_q[base + i] !== AW'(i) || wr_data_q[base + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL abort_ram[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, wr_addr_q[base + i], wr_data_q[base + i], i, exp_q[i]);
            end
        end
        checks++;
        if (viol !== v0) begin
            failures++; $display("FAIL abort_protocol got=%0d violations (%s) want=0", viol - v0, viol_msg);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int n, base, cnt;
        seed = DW'($urandom); src_lat = 1;
        base = wr_data_q.size();
        pulse_start();
        n = 0;
        while (!(src_req && src_addr == AW'(2)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200 || src_valid !== 1'b1) begin
            failures++; $display("FAIL rst_reach_fetch2 got n=%0d valid=%b want fetch of addr 2 with valid", n, src_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0 || state !== ST_IDLE) begin
            failures++; $display("FAIL rst_mid_fetch_outputs got=%h state=%0d want=0 state=%0d", all_outs(), state, ST_IDLE);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== 2) begin
            failures++; $display("FAIL rst_mid_fetch_writes got=%0d want=2", cnt);
        end
    endtask

    task automatic test_start_ignored();
        int n, base, v0, cnt, k1, k2;
        seed = DW'($urandom); src_lat = 2;
        base = wr_data_q.size(); v0 = viol;
        k1 = $urandom_range(3, 30);
        k2 = $urandom_range(31, 60);
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = (n == k1 || n == k2);
        end while (!(done || error) && n < 400);
        start = 1'b0;
        #1;
        checks++;
        if (n !== 4 * NWORDS || done !== 1'b1) begin
            failures++; $display("FAIL start_busy_done_cycle got=%0d done=%b want=%0d", n, done, 4 * NWORDS);
        end
        exp_q.delete();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back(src_word(seed, i));
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== NWORDS) begin
            failures++; $display("FAIL start_busy_write_count got=%0d want=%0d", cnt, NWORDS);
        end
        for (int i = 0; i < NWORDS && i < cnt; i++) begin
            checks++;
            if (wr_addr_q[base + i] !== AW'(i) || wr_data_q[base + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL start_busy_ram[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, wr_addr_q[base + i], wr_data_q[base + i], i, exp_q[i]);
            end
        end
        checks++;
        if (viol !== v0) begin
            failures++; $display("FAIL start_busy_protocol got=%0d violations (%s) want=0", viol - v0, viol_msg);
        end
        src_lat = 1;
    endtask

    task automatic test_spurious_valid();
        int n, base, v0, cnt;
        seed = DW'($urandom); src_lat = 1; spur_en = 1'b1;
        base = wr_data_q.size(); v0 = viol;
        pulse_start();
        wait_end(400, n);
        checks++;
        if (n !== 3 * NWORDS || done !== 1'b1) begin
            failures++; $display("FAIL spurious_done_cycle got=%0d done=%b want=%0d", n, done, 3 * NWORDS);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || {busy, cpu_hold, manual_mode, src_req} !== 4'b0) begin
            failures++; $display("FAIL spurious_done_stable got done=%b ctl=%b want done=1 ctl=0000",
                                 done, {busy, cpu_hold, manual_mode, src_req});
        end
        exp_q.delete();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back(src_word(seed, i));
        cnt = wr_data_q.size() - base;
        checks++;
        if (cnt !== NWORDS) begin
            failures++; $display("FAIL spurious_write_count got=%0d want=%0d", cnt, NWORDS);
        end
        for (int i = 0; i < NWORDS && i < cnt; i++) begin
            checks++;
            if (wr_addr_q[base + i] !== AW'(i) || wr_data_q[base + i] !== exp_q[i]) begin
                failures++;
                $display("FAIL spurious_ram[%0d] got addr=%0d data=%h want addr=%0d data=%h",
                         i, wr_addr_q[base + i], wr_data_q[base + i], i, exp_q[i]);
            end
        end
        checks++;
        if (viol !== v0) begin
            failures++; $display("FAIL spurious_protocol got=%0d violations (%s) want=0", viol - v0, viol_msg);
        end
        spur_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_latency();
        test_timeout();
        test_abort();
        test_reset_mid_fetch();
        test_start_ignored();
        test_spurious_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
